// File: rtl/nibble_add_sched.sv
// Two-requester round-robin adder that sums W-bit operands one nibble per cycle through a
// single 4-bit ripple slice. Define NIBBLE_ADD_SUB_EN to add per-requester subtract ports.
module nibble_add_sched #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [4*NIBBLES-1:0] req0_a,
    input  logic [4*NIBBLES-1:0] req0_b,
    input  logic                 req0_cin,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [4*NIBBLES-1:0] req1_a,
    input  logic [4*NIBBLES-1:0] req1_b,
    input  logic                 req1_cin,
`ifdef NIBBLE_ADD_SUB_EN
    input  logic                 req0_sub,
    input  logic                 req1_sub,
`endif
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*NIBBLES-1:0] res_sum,
    output logic                 res_cout,
    output logic                 res_id
);

    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned CW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_d;
    logic          r_prio;     // requester that wins when both are valid
    logic          r_carry;
    logic          r_id;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_accept;
    logic [W-1:0]  w_acc_a;
    logic [W-1:0]  w_acc_b;
    logic          w_acc_cin;
    logic [W-1:0]  w_b_sel;
    logic          w_cin_sel;
    logic [4:0]    w_slice;
    logic [W-1:0]  w_sum_next;

    // Grants are masked by rst_n so ready stays low while reset is held.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == IDLE && rst_n) begin
            if (req0_valid && (!req1_valid || !r_prio)) begin
                w_gnt0 = 1'b1;
            end else if (req1_valid) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign w_accept   = w_gnt0 | w_gnt1;
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    always_comb begin
        w_acc_a   = w_gnt1 ? req1_a : req0_a;
        w_acc_b   = w_gnt1 ? req1_b : req0_b;
        w_acc_cin = w_gnt1 ? req1_cin : req0_cin;
`ifdef NIBBLE_ADD_SUB_EN
        // a - b computed as a + ~b + 1; cout high means no borrow.
        if (w_gnt1 ? req1_sub : req0_sub) begin
            w_b_sel   = ~w_acc_b;
            w_cin_sel = 1'b1;
        end else begin
            w_b_sel   = w_acc_b;
            w_cin_sel = w_acc_cin;
        end
`else
        w_b_sel   = w_acc_b;
        w_cin_sel = w_acc_cin;
`endif
    end

    assign w_slice    = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'b0000, r_carry};
    // New slice enters at the top; after NIBBLES shifts the LSB slice sits at bit 0.
    assign w_sum_next = (r_sum >> 4) | (W'(w_slice[3:0]) << (W - 4));

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_d = ADD;
            ADD:     if (r_cnt == LAST) w_state_d = DONE;
            DONE:    if (res_ready) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_prio  <= 1'b0;
            r_carry <= 1'b0;
            r_id    <= 1'b0;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
        end else begin
            r_state <= w_state_d;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= w_acc_a;
                        r_b     <= w_b_sel;
                        r_carry <= w_cin_sel;
                        r_id    <= w_gnt1;
                        r_prio  <= ~w_gnt1;
                        r_cnt   <= '0;
                    end
                end
                ADD: begin
                    r_a     <= r_a >> 4;
                    r_b     <= r_b >> 4;
                    r_carry <= w_slice[4];
                    r_sum   <= w_sum_next;
                    r_cnt   <= r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign res_valid = (r_state == DONE);
    assign res_sum   = r_sum;
    assign res_cout  = r_carry;
    assign res_id    = r_id;

endmodule

// File: tb/tb_nibble_add_sched.sv
// Self-checking bench for nibble_add_sched: directed table, hand-written handshake/reset
// sequences and randomized traffic checked against an arithmetic round-robin model.
module tb_nibble_add_sched;

    localparam int unsigned NIBBLES = 4;
    localparam int unsigned W       = 4 * NIBBLES;

    logic         clk;
    logic         rst_n;
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;
`ifdef NIBBLE_ADD_SUB_EN
    logic         req0_sub;
    logic         req1_sub;
`endif
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_id;

    int checks;
    int errors;
    logic fav;  // model: requester favoured when both are valid

    nibble_add_sched #(
        .NIBBLES(NIBBLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req0_cin  (req0_cin),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .req1_cin  (req1_cin),
`ifdef NIBBLE_ADD_SUB_EN
        .req0_sub  (req0_sub),
        .req1_sub  (req1_sub),
`endif
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "simulation timeout");
    end

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_valid"}, 32'(res_valid), 32'd0);
        chk({name, "_sum"}, 32'(res_sum), 32'd0);
        chk({name, "_cout"}, 32'(res_cout), 32'd0);
        chk({name, "_id"}, 32'(res_id), 32'd0);
        chk({name, "_ready0"}, 32'(req0_ready), 32'd0);
        chk({name, "_ready1"}, 32'(req1_ready), 32'd0);
    endtask

    // Entered just after a rising edge with the DUT idle; leaves it idle again.
    task automatic txn(input string name, input bit v0, input bit v1,
                       input logic [W-1:0] a0, input logic [W-1:0] b0, input logic c0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1, input logic c1,
                       input logic [W-1:0] exp_sum, input logic exp_cout, input logic exp_id,
                       input int stall, input bit keep_loser);
        int lat;
        bit busy_ready;
        req0_valid = v0;
        req0_a     = a0;
        req0_b     = b0;
        req0_cin   = c0;
        req1_valid = v1;
        req1_a     = a1;
        req1_b     = b1;
        req1_cin   = c1;
        #1;
        chk({name, "_grant0"}, 32'(req0_ready), 32'(exp_id == 1'b0));
        chk({name, "_grant1"}, 32'(req1_ready), 32'(exp_id == 1'b1));
        @(posedge clk);
        #1;
        if (exp_id == 1'b0) begin
            req0_valid = 1'b0;
            req0_a     = W'($urandom);
            req0_b     = W'($urandom);
            req0_cin   = 1'($urandom);
            if (!keep_loser) req1_valid = 1'b0;
        end else begin
            req1_valid = 1'b0;
            req1_a     = W'($urandom);
            req1_b     = W'($urandom);
            req1_cin   = 1'($urandom);
            if (!keep_loser) req0_valid = 1'b0;
        end
        res_ready  = (stall == 0);
        lat        = 0;
        busy_ready = 1'b0;
        while (!res_valid && lat < 20) begin
            busy_ready |= req0_ready | req1_ready;
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(NIBBLES));
        chk({name, "_sum"}, 32'(res_sum), 32'(exp_sum));
        chk({name, "_cout"}, 32'(res_cout), 32'(exp_cout));
        chk({name, "_id"}, 32'(res_id), 32'(exp_id));
        for (int s = 0; s < stall; s++) begin
            busy_ready |= req0_ready | req1_ready;
            @(posedge clk);
            #1;
            chk({name, "_stall_valid"}, 32'(res_valid), 32'd1);
            chk({name, "_stall_sum"}, 32'(res_sum), 32'(exp_sum));
            chk({name, "_stall_cout"}, 32'(res_cout), 32'(exp_cout));
        end
        busy_ready |= req0_ready | req1_ready;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({name, "_idle_valid"}, 32'(res_valid), 32'd0);
        chk({name, "_busy_ready"}, 32'(busy_ready), 32'd0);
        fav = ~exp_id;
    endtask

    initial begin
        logic [W:0]   ref_r;
        logic         v0, v1, win, c0, c1;
        logic [W-1:0] a0, b0, a1, b1;
        int           stall;

        checks     = 0;
        errors     = 0;
        fav        = 1'b0;
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req0_a     = '0;
        req0_b     = '0;
        req0_cin   = 1'b0;
        req1_valid = 1'b0;
        req1_a     = '0;
        req1_b     = '0;
        req1_cin   = 1'b0;
        res_ready  = 1'b1;
`ifdef NIBBLE_ADD_SUB_EN
        req0_sub   = 1'b0;
        req1_sub   = 1'b0;
`endif

        vecs[0] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[1] = '{1'b1, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
        vecs[2] = '{1'b0, 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vecs[3] = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[6] = '{1'b0, 16'h00FF, 16'h0F01, 1'b1, 16'h1001, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk_all_zero("in_reset");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;

        // Both valid after reset: req0 first, then the held req1.
        txn("both_first", 1, 1, 16'h1234, 16'h1111, 0, 16'h0F0F, 16'h00F1, 0,
            16'h2345, 1'b0, 1'b0, 0, 1);
        txn("held_req1", 0, 1, 16'h1234, 16'h1111, 0, 16'h0F0F, 16'h00F1, 0,
            16'h1000, 1'b0, 1'b1, 0, 0);

        // Consumer stalls 3 cycles while req1 keeps asking.
        txn("stall3", 1, 1, 16'h00A5, 16'h0F0F, 1, 16'h4444, 16'h1111, 0,
            16'h0FB5, 1'b0, 1'b0, 3, 1);
        txn("rr_req1", 1, 1, 16'h00A5, 16'h0F0F, 1, 16'h4444, 16'h1111, 0,
            16'h5555, 1'b0, 1'b1, 0, 0);

        for (int i = 0; i < 7; i++) begin
            txn($sformatf("vec%0d", i), !vecs[i].id, vecs[i].id,
                vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].a, vecs[i].b, vecs[i].cin,
                vecs[i].sum, vecs[i].cout, vecs[i].id, 0, 0);
        end

        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom);
            v1 = 1'($urandom);
            if (!v0 && !v1) v0 = 1'b1;
            a0 = W'($urandom);
            b0 = W'($urandom);
            c0 = 1'($urandom);
            a1 = W'($urandom);
            b1 = W'($urandom);
            c1 = 1'($urandom);
            win   = (v0 && v1) ? fav : v1;
            ref_r = win ? ((W + 1)'(a1) + (W + 1)'(b1) + (W + 1)'(c1))
                        : ((W + 1)'(a0) + (W + 1)'(b0) + (W + 1)'(c0));
            stall = $urandom_range(0, 3);
            txn($sformatf("rand%0d", i), v0, v1, a0, b0, c0, a1, b1, c1,
                ref_r[W-1:0], ref_r[W], win, stall, 0);
        end

        // Reset during the second ADD cycle of a req0 operation.
        req0_valid = 1'b1;
        req0_a     = 16'hFFFF;
        req0_b     = 16'h0001;
        req0_cin   = 1'b0;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        req1_valid = 1'b1;
        #1;
        chk_all_zero("mid_add_reset");
        req1_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("reset_hold_valid", 32'(res_valid), 32'd0);
        end
        rst_n = 1'b1;
        fav   = 1'b0;
        txn("after_reset", 1, 1, 16'h0F0F, 16'h00F1, 0, 16'h1234, 16'h1111, 0,
            16'h1000, 1'b0, 1'b0, 0, 0);

`ifdef NIBBLE_ADD_SUB_EN
        req0_sub = 1'b1;
        txn("sub_borrow", 1, 0, 16'h0005, 16'h0007, 0, 16'h0000, 16'h0000, 0,
            16'hFFFE, 1'b0, 1'b0, 0, 0);
        txn("sub_ok", 1, 0, 16'h0007, 16'h0005, 0, 16'h0000, 16'h0000, 0,
            16'h0002, 1'b1, 1'b0, 0, 0);
        req0_sub = 1'b0;
        req1_sub = 1'b1;
        txn("sub_req1", 0, 1, 16'h0000, 16'h0000, 0, 16'h1000, 16'h0001, 0,
            16'h0FFF, 1'b1, 1'b1, 0, 0);
        req1_sub = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_add_sched.md
NIBBLE_ADD_SCHED -- requirements
Module: nibble_add_sched

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand; W = 4*NIBBLES.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req0_valid, input, 1, requester 0 presents an operation.
REQ-005 SHALL have port req0_ready, output, 1, requester 0 operation accepted this cycle when valid also high.
REQ-006 SHALL have ports req0_a and req0_b, input, W each, operands; and req0_cin, input, 1, carry-in.
REQ-007 SHALL have ports req1_valid, req1_ready, req1_a, req1_b and req1_cin, identical in meaning for requester 1.
REQ-008 SHALL have port res_valid, output, 1, result available.
REQ-009 SHALL have port res_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have ports res_sum, output, W, result; res_cout, output, 1, final carry; and res_id, output, 1, index of the served requester.

Function
REQ-011 SHALL implement FSM states IDLE, ADD and DONE; only the transitions IDLE->ADD, ADD->DONE and DONE->IDLE are legal.
REQ-012 In IDLE, SHALL assert reqN_ready combinationally only for the granted requester; no ready in ADD or DONE.
REQ-013 Grant SHALL be round-robin: a single valid requester wins; when both are valid, the requester not served last wins; after reset req0 is favoured.
REQ-014 On valid&&ready, SHALL capture a, b, cin and requester id, then enter ADD; later input changes are ignored.
REQ-015 ADD SHALL last exactly NIBBLES cycles, adding one 4-bit slice per cycle LSB-first through a single shared 4-bit ripple adder, with slice carry held in a carry register.
REQ-016 The slice counter SHALL run 0..NIBBLES-1; on the last slice the FSM enters DONE with the final carry in res_cout.
REQ-017 Latency: accept on edge 0, res_valid high from cycle NIBBLES+1 (cycle 5 at default).
REQ-018 In DONE, res_valid, res_sum, res_cout and res_id SHALL hold stable until res_valid&&res_ready, then the FSM returns to IDLE the next cycle.
REQ-019 With res_ready tied high, DONE SHALL last one cycle; the earliest next accept is in the following IDLE cycle.
REQ-020 A requester holding valid without ready SHALL not be dropped; it is served at its next grant.
REQ-021 res_valid SHALL be low outside DONE; res_sum SHALL be the W-bit modulo sum of a+b+cin, with the carry out of bit W-1 on res_cout.

Reset
REQ-022 Asserting rst_n low SHALL immediately force IDLE and abort any operation in ADD or DONE without producing a result.
REQ-023 During reset, all outputs, the carry register, the slice counter and the operand registers SHALL be 0; the round-robin pointer SHALL favour req0.
REQ-024 After rst_n deasserts, the first accept SHALL be possible on the first rising clk edge.

Configuration
REQ-025 Macro NIBBLE_ADD_SUB_EN SHALL control subtraction support.
REQ-026 With NIBBLE_ADD_SUB_EN defined, SHALL add input ports req0_sub and req1_sub, captured at accept; when set, b is inverted and carry-in forced to 1, giving a-b; res_cout=1 means no borrow.
REQ-027 Without NIBBLE_ADD_SUB_EN, SHALL have no sub ports or inversion logic; addition only.

Verification
REQ-028 req0 a=0xFFFF, b=0x0001, cin=0, res_ready=1 -> res_valid at cycle 5 with res_sum=0x0000, res_cout=1, res_id=0; cycle 6 IDLE.
REQ-029 req0 and req1 valid together after reset (0x1234+0x1111 and 0x0F0F+0x00F1) -> req0 served first (0x2345, cout 0), then req1 (0x1000, cout 0), each res_id correct.
REQ-030 res_ready held low 3 cycles in DONE -> res_valid and res_sum stay stable; no new ready until handshake completes, then IDLE.
REQ-031 rst_n pulsed low during the second ADD cycle -> res_valid stays 0, all outputs 0; a fresh request afterwards completes normally with correct latency.
REQ-032 With NIBBLE_ADD_SUB_EN: a=0x0005, b=0x0007, sub=1 -> res_sum=0xFFFE, res_cout=0; a=0x0007, b=0x0005 -> 0x0002, res_cout=1.
